// File: rtl/shift_reg_sipo_rx.sv
// ---------------------------------------------------------------------------
// shift_reg_sipo_rx
//
// Serial-in parallel-out receiver. This is the far end of the PISO shift
// register link. It takes one serial bit on each clock where shift_en is high,
// MSB first. Each completed WIDTH-bit word goes into a one-entry holding
// register, which the consumer reads through a valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   shift_en      data_in carries a valid serial bit this cycle
//   data_in       serial data, MSB of each word first
//   frame_start   abandons any partial word (resynchronisation point)
//   data_out      holding register contents, meaningful while data_valid=1
//   data_valid    holding register full
//   data_ready    consumer accepts data_out on an edge where data_valid=1
//   overrun       sticky flag: a completed word was dropped
//   clear_overrun synchronous clear of overrun
//   busy          partial word in progress (bit counter nonzero)
// ---------------------------------------------------------------------------
module shift_reg_sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             data_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             can_load;

  // The assembled word includes the bit being sampled on this edge, so a
  // completed word can go to the holding register on the same edge as its
  // last bit.
  assign word      = {sreg[WIDTH-2:0], data_in};
  // frame_start always overrides completion, so the word is not delivered.
  assign word_done = shift_en && !frame_start && (cnt == LAST_BIT);
  // The holding register is free if it is empty, or if it is being drained
  // on this same edge.
  assign can_load  = !data_valid || data_ready;

  assign busy = (cnt != '0);

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (frame_start) begin
      if (shift_en) begin
        sreg <= {{(WIDTH-1){1'b0}}, data_in};
        cnt  <= CW'(1);
      end else begin
        sreg <= '0;
        cnt  <= '0;
      end
    end else if (shift_en) begin
      sreg <= word;
      if (cnt == LAST_BIT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Holding register with a valid/ready handshake. A new word replaces a word
  // that is consumed on the same edge. If the consumer is stalled, the new
  // word is dropped and the held word is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (word_done && can_load) begin
      data_out   <= word;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky overrun flag. Setting it wins over a clear on the same edge, so a
  // drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (word_done && !can_load) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_sipo_rx
//
// Directed testbench for shift_reg_sipo_rx with WIDTH=4. The stimulus pushes
// every word that must reach the consumer into a queue. A separate monitor
// pops that queue each time the DUT presents a new word. Flags such as busy,
// overrun and the reset state are checked directly with checkOutput.
// ---------------------------------------------------------------------------
module tb_shift_reg_sipo_rx;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             shift_en;
  logic             data_in;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;
  logic             clear_overrun;
  logic             busy;

  int errors;
  int checks;
  logic [WIDTH-1:0] expected_q[$];

  shift_reg_sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .shift_en      (shift_en),
    .data_in       (data_in),
    .frame_start   (frame_start),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .busy          (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then return 1 time unit after the edge that
  // samples them.
  task automatic applyStimulus(input logic se, input logic din, input logic fs,
                               input logic rdy, input logic clr);
    shift_en      = se;
    data_in       = din;
    frame_start   = fs;
    data_ready    = rdy;
    clear_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Send a whole word MSB first. data_ready is high only on the last bit.
  task automatic sendWord(input logic [WIDTH-1:0] w, input logic rdy_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  task automatic consume();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: a new word is presented when data_valid is high, and either it
  // was low before or the previous edge carried a ready handshake.
  logic prev_valid;
  logic prev_ready;

  initial begin
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (data_valid && (!prev_valid || prev_ready)) begin
          checks++;
          if (expected_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_word: got %0h, expected none", data_out);
          end else begin
            logic [WIDTH-1:0] exp_w;
            exp_w = expected_q.pop_front();
            if (data_out !== exp_w) begin
              errors++;
              $display("[TB] FAIL word: got %0h, expected %0h", data_out, exp_w);
            end
          end
        end
        prev_valid = data_valid;
        prev_ready = data_ready;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    shift_en      = 1'b0;
    data_in       = 1'b0;
    frame_start   = 1'b0;
    data_ready    = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(data_valid), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic word 1011. busy is high after bits 1..3 and low after bit 4.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_b1", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_b2", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_b3", 32'(busy), 32'd1);
    expected_q.push_back(4'hB);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_b4", 32'(busy), 32'd0);
    checkOutput("t1_valid", 32'(data_valid), 32'd1);
    consume();
    checkOutput("t1_consumed", 32'(data_valid), 32'd0);

    // Gap of 3 idle cycles between bits 2 and 3. Expected word is 1100.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_gap_busy", 32'(busy), 32'd1);
      checkOutput("t2_gap_valid", 32'(data_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expected_q.push_back(4'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

    // Overrun. A is held, 5 is dropped, then overrun is cleared.
    expected_q.push_back(4'hA);
    sendWord(4'hA, 1'b0);
    checkOutput("t3_no_overrun", 32'(overrun), 32'd0);
    sendWord(4'h5, 1'b0);
    checkOutput("t3_overrun", 32'(overrun), 32'd1);
    checkOutput("t3_data_kept", 32'(data_out), 32'hA);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_overrun_clr", 32'(overrun), 32'd0);
    consume();

    // Completion on the same edge as consume. 9 replaces 3, with no overrun.
    expected_q.push_back(4'h3);
    sendWord(4'h3, 1'b0);
    expected_q.push_back(4'h9);
    sendWord(4'h9, 1'b1);
    checkOutput("t4_valid", 32'(data_valid), 32'd1);
    checkOutput("t4_data", 32'(data_out), 32'h9);
    checkOutput("t4_overrun", 32'(overrun), 32'd0);
    consume();

    // frame_start with shift_en. 1,1 are discarded and 0,1,1,0 gives 6.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_busy_fs", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expected_q.push_back(4'h6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

    // frame_start alone clears a partial word.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_fs_idle_busy", 32'(busy), 32'd0);

    // frame_start on the would-be completion edge. Nothing is delivered and
    // 0,1,0,1 gives 5.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_fs_win_valid", 32'(data_valid), 32'd0);
    checkOutput("t5_fs_win_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expected_q.push_back(4'h5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    consume();

    // Asynchronous reset while a word is held and a partial word is pending.
    // Overrun is set first so its reset is also seen.
    expected_q.push_back(4'h2);
    sendWord(4'h2, 1'b0);
    sendWord(4'h7, 1'b0);
    checkOutput("t6_pre_overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(data_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(data_out), 32'd0);
    checkOutput("t6_rst_overrun", 32'(overrun), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    shift_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expected_q.push_back(4'hF);
    sendWord(4'hF, 1'b0);
    checkOutput("t6_valid", 32'(data_valid), 32'd1);
    consume();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    checkOutput("queue_drained", 32'(expected_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
